// File: rtl/data_mem_rsp_pkg.sv
// Shared types and defaults for the data memory responder: FSM states,
// default geometry and the width of the wait counter.
package data_mem_rsp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_DEPTH_WORDS = 256;
  localparam int DEFAULT_LATENCY     = 2;
  localparam int CNT_W               = 3;

endpackage

// File: rtl/data_mem_rsp_array.sv
// Word-addressed storage for the responder: synchronous write,
// combinational read, every word cleared while RST is high.
module data_mem_rsp_array
  import data_mem_rsp_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
  input  logic [31:0]                    wr_data,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
  output logic [31:0]                    rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder: accepts one request, waits
// LATENCY cycles, commits the access and holds the response until consumed.
module data_mem_responder
  import data_mem_rsp_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int               IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0]      ADDR_LIMIT = 32'(DEPTH_WORDS * 4);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(LATENCY - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             lat_write;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic             addr_err;
  logic             commit;
  logic             mem_we;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      mem_rdata;

  assign addr_err = (lat_addr[1:0] != 2'b00) || (lat_addr >= ADDR_LIMIT);
  assign word_idx = lat_addr[IDX_W+1:2];
  // The access happens on the single WAIT-to-RESP edge.
  assign commit   = (state == WAIT) && (wait_cnt == '0);
  assign mem_we   = commit && lat_write && !addr_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid)        next_state = WAIT;
      WAIT:    if (wait_cnt == '0)   next_state = RESP;
      RESP:    if (rsp_ready)        next_state = IDLE;
      default:                       next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE:    req_ready = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt  <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        wait_cnt  <= CNT_LOAD;
      end else if (state == WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - CNT_W'(1);
      end
      // Response fields only change on commit, so they stay put throughout RESP.
      if (commit) begin
        rsp_rdata <= (lat_write || addr_err) ? '0 : mem_rdata;
        rsp_err   <= addr_err;
      end
    end
  end

  data_mem_rsp_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .CLK    (CLK),
    .RST    (RST),
    .wr_en  (mem_we),
    .wr_idx (word_idx),
    .wr_data(lat_wdata),
    .rd_idx (word_idx),
    .rd_data(mem_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table of single transactions
// plus hand-written back-pressure, mid-transaction reset and sweep sequences.
module tb_data_mem_responder;

  localparam int DEPTH_WORDS = 256;
  localparam int LATENCY     = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int last_accept = 0;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  data_mem_responder #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .LATENCY    (LATENCY)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Called at a falling edge. Returns at the falling edge where rsp_valid is
  // first seen; lat counts cycles from the acceptance cycle (which is cycle 0).
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d, output int lat);
    int guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL req_ready_timeout: got 0, expected 1 within 20 cycles");
    end
    req_valid   = 1'b1;
    req_write   = w;
    req_addr    = a;
    req_wdata   = d;
    last_accept = cycle;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int prev_accept;
    logic [31:0] d;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0014, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[4]  = '{1'b1, 32'h0000_0400, 32'h1234_5678, 32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0011, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b1};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].write, vecs[i].addr, vecs[i].wdata, lat);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(LATENCY + 1));
      checkOutput($sformatf("vec%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
      checkOutput($sformatf("vec%0d_req_ready_busy", i), 32'(req_ready), 32'd0);
    end

    // Back-pressure: hold the response while a stray store is presented.
    @(negedge clk);
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, lat);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h0000_0100 + 32'(i * 4);
      req_wdata = 32'hBAD0_0000 + 32'(i);
      @(negedge clk);
      checkOutput($sformatf("hold%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("hold%0d_rsp_rdata", i), rsp_rdata, 32'hDEAD_BEEF);
      checkOutput($sformatf("hold%0d_rsp_err", i), 32'(rsp_err), 32'd0);
      checkOutput($sformatf("hold%0d_req_ready", i), 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_req_ready", 32'(req_ready), 32'd1);
    checkOutput("release_rsp_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'h0000_0100 + 32'(i * 4), 32'h0, lat);
      checkOutput($sformatf("ignored_store%0d_rdata", i), rsp_rdata, 32'd0);
    end

    // Reset during WAIT of a store: the store is dropped and no response appears.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0020;
    req_wdata = 32'h0000_0055;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
    d = 32'd0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) d = d + 32'd1;
      @(negedge clk);
    end
    checkOutput("abort_no_response", d, 32'd0);
    applyStimulus(1'b0, 32'h0000_0020, 32'h0, lat);
    checkOutput("abort_load_rdata", rsp_rdata, 32'd0);
    checkOutput("abort_load_err", 32'(rsp_err), 32'd0);

    // Full sweep of back-to-back store/load pairs, then an independent readback.
    @(negedge clk);
    prev_accept = -1;
    for (int i = 0; i < DEPTH_WORDS; i++) begin
      d = (32'(i) * 32'h0101_0101) ^ 32'h5A00_C300;
      applyStimulus(1'b1, 32'(i * 4), d, lat);
      if (prev_accept >= 0)
        checkOutput($sformatf("sweep%0d_store_period", i), 32'(last_accept - prev_accept), 32'(LATENCY + 2));
      prev_accept = last_accept;
      applyStimulus(1'b0, 32'(i * 4), 32'h0, lat);
      checkOutput($sformatf("sweep%0d_load_period", i), 32'(last_accept - prev_accept), 32'(LATENCY + 2));
      prev_accept = last_accept;
      checkOutput($sformatf("sweep%0d_rdata", i), rsp_rdata, d);
      checkOutput($sformatf("sweep%0d_err", i), 32'(rsp_err), 32'd0);
    end
    for (int i = 0; i < DEPTH_WORDS; i++) begin
      d = (32'(i) * 32'h0101_0101) ^ 32'h5A00_C300;
      applyStimulus(1'b0, 32'(i * 4), 32'h0, lat);
      checkOutput($sformatf("readback%0d_rdata", i), rsp_rdata, d);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit storage words (power of two, 16..1024).
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles between acceptance and response (1..7).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  initiator consumes response.
REQ-012 SHALL have port rsp_rdata  output  32  load data.
REQ-013 SHALL have port rsp_err  output  1  request was misaligned or out of range.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL accept a request on a cycle where req_valid && req_ready; it SHALL latch req_write, req_addr and req_wdata, load the wait counter with LATENCY-1, and enter WAIT.
REQ-016 SHALL ignore req_* inputs outside IDLE; latched values SHALL NOT change until the next acceptance.
REQ-017 In WAIT it SHALL decrement the counter each cycle; when the counter reads 0 it SHALL enter RESP on the next edge, so rsp_valid rises exactly LATENCY+1 cycles after the acceptance edge.
REQ-018 SHALL flag an error when addr[1:0] != 0 or addr >= DEPTH_WORDS*4; the word index SHALL be addr[log2(DEPTH_WORDS)+1:2].
REQ-019 On the WAIT-to-RESP edge, a valid store SHALL write wdata to the indexed word; an erroneous store SHALL leave memory unchanged.
REQ-020 On the same edge, rsp_rdata SHALL capture the indexed word for a valid load, and SHALL be 0 for stores and errors; rsp_err SHALL capture the error flag.
REQ-021 rsp_rdata and rsp_err SHALL be held stable while rsp_valid = 1.
REQ-022 RESP SHALL persist until rsp_ready = 1; on that edge the FSM SHALL return to IDLE, and rsp_valid SHALL fall on the following cycle.
REQ-023 No request SHALL be accepted in the cycle rsp_ready is sampled; the next acceptance is possible at the earliest one cycle later. Minimum period is LATENCY+2 cycles per transaction.
REQ-024 rsp_ready asserted outside RESP SHALL have no effect.
REQ-025 A load issued after a store to the same address SHALL return the stored data (read-after-write ordering is inherent because only one transaction is in flight).

Reset
REQ-026 While RST = 1 at a rising edge: state = IDLE, counter = 0, req_ready = 1 after reset, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, and all storage words = 0.
REQ-027 Reset asserted mid-transaction (WAIT or RESP) SHALL abort it; an uncommitted store SHALL be discarded and no response SHALL be issued.

Structure
REQ-028 SHALL place the following in shared package data_mem_rsp_pkg: the state enum, default DEPTH_WORDS and LATENCY, and the counter width (3 bits).
REQ-029 SHALL place storage in one sub-module, data_mem_rsp_array: synchronous write, combinational read, synchronous clear on RST.

Verification
REQ-030 Reset, then store 0x0000_0010 <- 0xDEADBEEF (LATENCY = 2): rsp_valid rises 3 cycles after acceptance, rsp_err = 0, rsp_rdata = 0.
REQ-031 Load 0x10 after REQ-030: rsp_rdata = 0xDEADBEEF, rsp_err = 0; a load of 0x14 returns 0.
REQ-032 Load 0x0000_0013 (misaligned) and store 0x0000_0400 (out of range, DEPTH 256): rsp_err = 1, rsp_rdata = 0; a reload of word 0 confirms memory is unchanged.
REQ-033 Hold rsp_ready = 0 for 5 cycles in RESP, with req_valid held high and changing req_addr: rsp_valid and rsp_rdata stay stable and req_ready = 0; after rsp_ready = 1, req_ready returns 1 on the next cycle.
REQ-034 Assert RST in WAIT of a store of 0x55 to 0x20: no response is issued, req_ready = 1 after reset, and a load of 0x20 returns 0.
REQ-035 Run back-to-back store/load pairs to addresses 0x0..0x3FC with rsp_ready tied high: every load matches its store, and the period is 4 cycles per transaction.
